// File: rtl/rf_write_sequencer.sv
// Register-file write sequencer: arbitrates two writeback channels into a small FIFO and
// issues one registered register-file write per cycle, exporting a per-register pending vector.
module rf_write_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_a_valid,
  output logic                   o_a_ready,
  input  logic [AW-1:0]          i_a_addr,
  input  logic [DW-1:0]          i_a_data,
  input  logic                   i_b_valid,
  output logic                   o_b_ready,
  input  logic [AW-1:0]          i_b_addr,
  input  logic [DW-1:0]          i_b_data,
  output logic                   o_rf_we,
  output logic [AW-1:0]          o_rf_waddr,
  output logic [DW-1:0]          o_rf_wdata,
  output logic [31:0]            o_pending,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_rr_last_b;
  logic          r_rf_we;
  logic [AW-1:0] r_rf_waddr;
  logic [DW-1:0] r_rf_wdata;

  logic          w_full;
  logic          w_empty;
  logic          w_both;
  logic          w_a_ready;
  logic          w_b_ready;
  logic          w_grant_a;
  logic          w_grant_b;
  logic [AW-1:0] w_in_addr;
  logic [DW-1:0] w_in_data;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_off;
  logic [31:0]   w_pending;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_both  = i_a_valid && i_b_valid;

  // On contention the channel not granted last wins; an idle channel still sees ready.
  assign w_a_ready = !w_full && !(w_both && !r_rr_last_b);
  assign w_b_ready = !w_full && !(w_both && r_rr_last_b);
  assign w_grant_a = i_a_valid && w_a_ready;
  assign w_grant_b = i_b_valid && w_b_ready;

  assign w_in_addr = w_grant_a ? i_a_addr : i_b_addr;
  assign w_in_data = w_grant_a ? i_a_data : i_b_data;
  // Writes to r0 complete the handshake but are dropped.
  assign w_push    = (w_grant_a || w_grant_b) && (w_in_addr != '0);
  assign w_pop     = !w_empty;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rr_last_b <= 1'b1;
      r_rf_we     <= 1'b0;
      r_rf_waddr  <= '0;
      r_rf_wdata  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_grant_a) begin
        r_rr_last_b <= 1'b0;
      end else if (w_grant_b) begin
        r_rr_last_b <= 1'b1;
      end
      r_rf_we <= w_pop;
      if (w_pop) begin
        r_rf_waddr <= r_addr[r_rd_ptr];
        r_rf_wdata <= r_data[r_rd_ptr];
      end
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= w_in_addr;
      r_data[r_wr_ptr] <= w_in_data;
    end
  end

  always_comb begin
    w_pending = '0;
    w_off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_rd_ptr;
      if ({1'b0, w_off} < r_count) w_pending[r_addr[i]] = 1'b1;
    end
    if (r_rf_we) w_pending[r_rf_waddr] = 1'b1;
    w_pending[0] = 1'b0;
  end

  assign o_a_ready  = w_a_ready;
  assign o_b_ready  = w_b_ready;
  assign o_rf_we    = r_rf_we;
  assign o_rf_waddr = r_rf_waddr;
  assign o_rf_wdata = r_rf_wdata;
  assign o_pending  = w_pending;
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_empty    = w_empty;

endmodule

// File: tb/tb_rf_write_sequencer.sv
// Self-checking bench for rf_write_sequencer: a small acceptance model feeds a scoreboard
// queue that a monitor drains against every register-file write.
module tb_rf_write_sequencer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [4:0]  a_addr = '0;
  logic [31:0] a_data = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [4:0]  b_addr = '0;
  logic [31:0] b_data = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  wr_t sb[$];
  int  m_count = 0;
  bit  m_rr_last_b = 1'b1;
  bit  exp_a_rdy, exp_b_rdy;
  bit  last_grant_a, last_grant_b;
  int  n_checks = 0;
  int  n_pass = 0;
  int  n_writes = 0;

  rf_write_sequencer #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_a_valid (a_valid),
    .o_a_ready (a_ready),
    .i_a_addr  (a_addr),
    .i_a_data  (a_data),
    .i_b_valid (b_valid),
    .o_b_ready (b_ready),
    .i_b_addr  (b_addr),
    .i_b_data  (b_data),
    .o_rf_we   (rf_we),
    .o_rf_waddr(rf_waddr),
    .o_rf_wdata(rf_wdata),
    .o_pending (pending),
    .o_count   (count),
    .o_full    (full),
    .o_empty   (empty)
  );

  always #5 clk = ~clk;

  // Every issued write must match the oldest accepted non-r0 transfer.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (!reset && rf_we) begin
      n_writes++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL rf_write: got addr=%0d data=%h, required no write", rf_waddr, rf_wdata);
      end else begin
        e = sb.pop_front();
        if (rf_waddr !== e.addr || rf_wdata !== e.data)
          $display("FAIL rf_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   rf_waddr, rf_wdata, e.addr, e.data);
        else n_pass++;
      end
    end
  end

  // Called just after a negedge: apply inputs and predict readys.
  task automatic drive(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit bv, input logic [4:0] ba, input logic [31:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    exp_a_rdy = (m_count < DEPTH) && !(av && bv && !m_rr_last_b);
    exp_b_rdy = (m_count < DEPTH) && !(av && bv && m_rr_last_b);
  endtask

  // Advance one clock, updating the model, and return at the following negedge.
  task automatic tick();
    bit pop, push;
    @(posedge clk);
    pop = (m_count > 0);
    push = 1'b0;
    last_grant_a = a_valid && exp_a_rdy;
    last_grant_b = b_valid && exp_b_rdy;
    if (last_grant_a) begin
      m_rr_last_b = 1'b0;
      if (a_addr != 0) begin sb.push_back('{addr: a_addr, data: a_data}); push = 1'b1; end
    end else if (last_grant_b) begin
      m_rr_last_b = 1'b1;
      if (b_addr != 0) begin sb.push_back('{addr: b_addr, data: b_data}); push = 1'b1; end
    end
    m_count = m_count + int'(push) - int'(pop);
    @(negedge clk);
  endtask

  task automatic idle_ticks(input int n);
    drive(0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic apply_reset();
    #2 reset = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    sb.delete();
    m_count = 0;
    m_rr_last_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (rf_we !== 1'b0 || pending !== 32'h0 || empty !== 1'b1 || count !== 3'd0)
      $display("FAIL reset_state: rf_we=%b pending=%h empty=%b count=%0d, required 0/0/1/0",
               rf_we, pending, empty, count);
    else n_pass++;
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0)
      $display("FAIL reset_idle: a_ready=%b b_ready=%b waddr=%0d wdata=%h, required 1/1/0/0",
               a_ready, b_ready, rf_waddr, rf_wdata);
    else n_pass++;
    idle_ticks(1);
  endtask

  task automatic test_single_a();
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    #1;
    n_checks++;
    if (a_ready !== 1'b1) $display("FAIL single_a_ready: got %b, required 1", a_ready);
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (pending[5] !== 1'b1 || rf_we !== 1'b0 || count !== 3'd1)
      $display("FAIL single_a_queued: pending5=%b rf_we=%b count=%0d, required 1/0/1",
               pending[5], rf_we, count);
    else n_pass++;
    tick();
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF || pending[5] !== 1'b1)
      $display("FAIL single_a_issue: we=%b addr=%0d data=%h p5=%b, required 1/5/deadbeef/1",
               rf_we, rf_waddr, rf_wdata, pending[5]);
    else n_pass++;
    tick();
    n_checks++;
    if (rf_we !== 1'b0 || pending !== 32'h0 || rf_waddr !== 5'd5)
      $display("FAIL single_a_done: we=%b pending=%h waddr=%0d, required 0/0/5",
               rf_we, pending, rf_waddr);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [31:0] da, db;
    apply_reset();
    da = 32'hA000_0000;
    db = 32'hB000_0000;
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'd1, da, 1, 5'd2, db);
      #1;
      n_checks++;
      if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1))
        $display("FAIL contention_grant%0d: a_ready=%b b_ready=%b, required %b/%b",
                 i, a_ready, b_ready, (i % 2 == 0), (i % 2 == 1));
      else n_pass++;
      tick();
      if (last_grant_a) da++;
      if (last_grant_b) db++;
    end
    idle_ticks(DEPTH + 2);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(3 + i), 32'hC0DE_0000 + i, 0, 0, 0);
      tick();
    end
    apply_reset_check();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (rf_we !== 1'b0) $display("FAIL reset_mid_quiet%0d: rf_we=%b, required 0", i, rf_we);
      else n_pass++;
    end
  endtask

  task automatic apply_reset_check();
    #2 reset = 1'b1;
    a_valid = 1'b0;
    #1;
    n_checks++;
    if (count !== 3'd0 || rf_we !== 1'b0 || pending !== 32'h0 || empty !== 1'b1)
      $display("FAIL reset_mid: count=%0d rf_we=%b pending=%h empty=%b, required 0/0/0/1",
               count, rf_we, pending, empty);
    else n_pass++;
    sb.delete();
    m_count = 0;
    m_rr_last_b = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_fill();
    int ai, bi, acc, w0, guard;
    ai = 0; bi = 0; acc = 0; guard = 0;
    w0 = n_writes;
    while (acc < 6 && guard < 20) begin
      drive(ai < 3, 5'(10 + ai), 32'h1000 + ai, bi < 3, 5'(20 + bi), 32'h2000 + bi);
      tick();
      guard++;
      if (last_grant_a) begin ai++; acc++; end
      if (last_grant_b) begin bi++; acc++; end
      n_checks++;
      if (count > 3'(DEPTH) || int'(count) != m_count)
        $display("FAIL fill_count: got %0d, required %0d (<= %0d)", count, m_count, DEPTH);
      else n_pass++;
    end
    idle_ticks(DEPTH + 2);
    n_checks++;
    if (n_writes - w0 != 6 || sb.size() != 0)
      $display("FAIL fill_all_issued: writes=%0d left=%0d, required 6/0", n_writes - w0,
               sb.size());
    else n_pass++;
  endtask

  task automatic test_reg0();
    drive(1, 5'd0, 32'h1234, 0, 0, 0);
    #1;
    n_checks++;
    if (a_ready !== 1'b1) $display("FAIL reg0_ready: got %b, required 1", a_ready);
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (count !== 3'd0 || pending !== 32'h0)
      $display("FAIL reg0_dropped: count=%0d pending=%h, required 0/0", count, pending);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (rf_we !== 1'b0) $display("FAIL reg0_no_write%0d: rf_we=%b, required 0", i, rf_we);
      else n_pass++;
    end
  endtask

  task automatic test_same_reg();
    drive(1, 5'd7, 32'h11, 0, 0, 0);
    tick();
    n_checks++;
    if (pending[7] !== 1'b1) $display("FAIL same_reg_p0: pending7=%b, required 1", pending[7]);
    else n_pass++;
    drive(1, 5'd7, 32'h22, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (pending[7] !== 1'b1 || rf_we !== 1'b1 || rf_wdata !== 32'h11)
      $display("FAIL same_reg_first: p7=%b we=%b data=%h, required 1/1/11",
               pending[7], rf_we, rf_wdata);
    else n_pass++;
    tick();
    n_checks++;
    if (pending[7] !== 1'b1 || rf_we !== 1'b1 || rf_wdata !== 32'h22)
      $display("FAIL same_reg_second: p7=%b we=%b data=%h, required 1/1/22",
               pending[7], rf_we, rf_wdata);
    else n_pass++;
    tick();
    n_checks++;
    if (pending[7] !== 1'b0 || rf_we !== 1'b0)
      $display("FAIL same_reg_clear: p7=%b we=%b, required 0/0", pending[7], rf_we);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_contention();
    test_reset_mid();
    test_fill();
    test_reg0();
    test_same_reg();
    idle_ticks(2);
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drained: %0d left, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
